// File: rtl/stat_pkg.sv
// Shared types, constants and width helpers for the frame-statistics sequencer.
package stat_pkg;

    typedef enum logic [2:0] {
        StCollect,
        StMean,
        StVar,
        StScale,
        StOut
    } state_e;

    localparam int unsigned W = 16;

    localparam logic signed [15:0] MIN_INIT = 16'sh7FFF;
    localparam logic signed [15:0] MAX_INIT = 16'sh8000;

    // Reciprocal of the frame length in Q15, truncated.
    function automatic logic [15:0] k_of(input int unsigned n);
        return 16'(32768 / n);
    endfunction

    // Signed running-sum width: sample width plus growth over n samples.
    function automatic int unsigned sum_w(input int unsigned n);
        return W + $clog2(n);
    endfunction

    // Unsigned sum-of-squares width: 34-bit square plus growth over n terms.
    function automatic int unsigned sq_w(input int unsigned n);
        return 34 + $clog2(n);
    endfunction

endpackage

// File: rtl/stat_buf.sv
// Frame sample store: N words, one synchronous write port, one combinational read port.
module stat_buf #(
    parameter int unsigned N  = 7,
    parameter int unsigned W  = 16,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [N];

    // Storage needs no reset: every word is rewritten before the variance pass reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stat_seq.sv
// Streaming frame-statistics sequencer: collects N samples, then computes
// min/max, floor mean and scaled dispersion with one shared squarer.
module stat_seq #(
    parameter int unsigned N = 7,
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    input  logic signed [W-1:0] s_data,
    output logic                s_ready,
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [15:0]  min,
    output logic signed [15:0]  max,
    output logic signed [15:0]  mean,
    output logic [34:0]         disp
);

    import stat_pkg::*;

    localparam int unsigned CW    = $clog2(N);
    localparam int unsigned SUM_W = sum_w(N);
    localparam int unsigned SQ_W  = sq_w(N);
    localparam int unsigned MPW   = SUM_W + 17;
    localparam int unsigned DPW   = SQ_W + 16;
    localparam logic [15:0]   K    = k_of(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [CW-1:0]             idx_q;
    logic signed [15:0]        run_min_q;
    logic signed [15:0]        run_max_q;
    logic signed [SUM_W-1:0]   sum_q;
    logic signed [15:0]        mean_q;
    logic [SQ_W-1:0]           sumsq_q;

    logic                      hs;
    logic [W-1:0]              rd_data;
    logic signed [W:0]         d;
    logic signed [33:0]        sq;
    logic signed [MPW-1:0]     mean_prod;
    logic [DPW-1:0]            disp_prod;
    logic                      unused_bits;

    assign hs = s_valid && s_ready;

    stat_buf #(
        .N (N),
        .W (W)
    ) u_buf (
        .clk   (clk),
        .we    (hs),
        .waddr (cnt_q),
        .wdata (s_data),
        .raddr (idx_q),
        .rdata (rd_data)
    );

    // Deviation from the mean and its square through the single shared multiplier.
    assign d  = $signed({rd_data[W-1], rd_data}) - $signed({mean_q[15], mean_q});
    assign sq = 34'(d) * 34'(d);

    // sum*K then bits [30:15] give the floor of the arithmetic shift, low 16 bits.
    assign mean_prod = MPW'(sum_q) * MPW'($signed({1'b0, K}));
    assign disp_prod = DPW'(sumsq_q) * DPW'(K);

    assign unused_bits = ^{mean_prod[MPW-1:31], mean_prod[14:0],
                           disp_prod[DPW-1:50], disp_prod[14:0]};

    // Sequencer FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StCollect;
            cnt_q     <= '0;
            idx_q     <= '0;
            run_min_q <= MIN_INIT;
            run_max_q <= MAX_INIT;
            sum_q     <= '0;
            mean_q    <= '0;
            sumsq_q   <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            min       <= '0;
            max       <= '0;
            mean      <= '0;
            disp      <= '0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (hs) begin
                        if (s_data < run_min_q) run_min_q <= s_data;
                        if (s_data > run_max_q) run_max_q <= s_data;
                        sum_q <= sum_q + SUM_W'(s_data);
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            s_ready <= 1'b0;
                            state_q <= StMean;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StMean: begin
                    mean_q  <= mean_prod[30:15];
                    idx_q   <= '0;
                    sumsq_q <= '0;
                    state_q <= StVar;
                end
                StVar: begin
                    sumsq_q <= sumsq_q + SQ_W'($unsigned(sq));
                    if (idx_q == LAST) begin
                        state_q <= StScale;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StScale: begin
                    min     <= run_min_q;
                    max     <= run_max_q;
                    mean    <= mean_q;
                    disp    <= disp_prod[49:15];
                    m_valid <= 1'b1;
                    state_q <= StOut;
                end
                StOut: begin
                    if (m_ready) begin
                        run_min_q <= MIN_INIT;
                        run_max_q <= MAX_INIT;
                        sum_q     <= '0;
                        cnt_q     <= '0;
                        m_valid   <= 1'b0;
                        s_ready   <= 1'b1;
                        state_q   <= StCollect;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_seq.sv
// Self-checking bench for stat_seq: fixed vectors, corner sequences, random frames
// against a plain-arithmetic reference model.
module tb_stat_seq;

    localparam int     N = 7;
    localparam longint K = 32768 / N;

    typedef logic [N-1:0][15:0] frame_t;

    typedef struct packed {
        frame_t             s;
        logic               gap;
        logic signed [15:0] e_min;
        logic signed [15:0] e_max;
        logic signed [15:0] e_mean;
        logic [34:0]        e_disp;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               s_valid = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_ready;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] dmin, dmax, dmean;
    logic [34:0]        ddisp;

    int     checks = 0;
    int     passes = 0;
    longint cyc = 0;
    longint last_acc = 0;
    vec_t   vecs [5];

    stat_seq #(
        .N (N),
        .W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .min     (dmin),
        .max     (dmax),
        .mean    (dmean),
        .disp    (ddisp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic frame_t pack7(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6);
        frame_t r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6);
        return r;
    endfunction

    // Reference statistics straight from the definitions, in 64-bit arithmetic.
    function automatic void model(input frame_t smp, output longint mn, output longint mx,
                                  output longint mu, output longint dp);
        longint s = 0;
        longint ss = 0;
        longint x;
        mn = 32767;
        mx = -32768;
        for (int j = 0; j < N; j++) begin
            x = longint'($signed(smp[j]));
            if (x < mn) mn = x;
            if (x > mx) mx = x;
            s += x;
        end
        mu = (s * K) >>> 15;
        for (int j = 0; j < N; j++) begin
            x = longint'($signed(smp[j]));
            ss += (x - mu) * (x - mu);
        end
        dp = (ss * K) >>> 15;
    endfunction

    task automatic check_outs(input string tag, input longint mn, input longint mx,
                              input longint mu, input longint dp);
        check({tag, " min"}, longint'(dmin), mn);
        check({tag, " max"}, longint'(dmax), mx);
        check({tag, " mean"}, longint'(dmean), mu);
        check({tag, " disp"}, longint'(ddisp), dp);
    endtask

    // Offer one sample and return just after the edge that accepts it.
    task automatic push(input logic [15:0] x);
        int n = 0;
        s_valid = 1'b1;
        s_data  = x;
        while (!s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) check("push s_ready timeout", longint'(s_ready), 1);
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic run_frame(input frame_t smp, input logic gap, input longint mn,
                             input longint mx, input longint mu, input longint dp,
                             input string tag);
        int n = 0;
        for (int j = 0; j < N; j++) begin
            push(smp[j]);
            if (gap && j < N - 1) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        while (!m_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, cyc - last_acc, N + 2);
        check_outs(tag, mn, mx, mu, dp);
    endtask

    task automatic pop(input int delay);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("s_ready after pop", longint'(s_ready), 1);
        check("m_valid after pop", longint'(m_valid), 0);
    endtask

    initial begin
        vecs[0] = '{s: pack7(5032, -1767, -15, 18932, 1000, 0, -6057), gap: 1'b0,
                    e_min: -16'sd6057, e_max: 16'sd18932, e_mean: 16'sd2446,
                    e_disp: 35'd54663520};
        vecs[1] = '{s: pack7(100, 100, 100, 100, 100, 100, 100), gap: 1'b0,
                    e_min: 16'sd100, e_max: 16'sd100, e_mean: 16'sd99, e_disp: 35'd0};
        vecs[2] = '{s: pack7(-1, -1, -1, -1, -1, -1, -1), gap: 1'b1,
                    e_min: -16'sd1, e_max: -16'sd1, e_mean: -16'sd1, e_disp: 35'd0};
        vecs[3] = '{s: pack7(-32768, -32768, -32768, -32768, -32768, -32768, -32768),
                    gap: 1'b0, e_min: -16'sd32768, e_max: -16'sd32768,
                    e_mean: -16'sd32767, e_disp: 35'd0};
        vecs[4] = vecs[0];
        vecs[4].gap = 1'b1;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("reset s_ready", longint'(s_ready), 1);
        check("reset m_valid", longint'(m_valid), 0);
        check_outs("reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors.
        for (int r = 0; r < 5; r++) begin
            run_frame(vecs[r].s, vecs[r].gap, longint'(vecs[r].e_min),
                      longint'(vecs[r].e_max), longint'(vecs[r].e_mean),
                      longint'(vecs[r].e_disp), $sformatf("vec%0d", r));
            pop(0);
        end

        // Consumer stall in OUT with a pending sample that must not be taken.
        run_frame(vecs[0].s, 1'b0, -6057, 18932, 2446, 54663520, "pre-hold");
        s_valid = 1'b1;
        s_data  = -16'sd30000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold s_ready", longint'(s_ready), 0);
            check("hold m_valid", longint'(m_valid), 1);
            check_outs("hold", -6057, 18932, 2446, 54663520);
        end
        pop(0);
        run_frame(vecs[1].s, 1'b0, 100, 100, 99, 0, "post-hold");
        pop(1);

        // Asynchronous reset in the middle of the variance pass.
        for (int j = 0; j < N; j++) push(vecs[3].s[j]);
        s_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midvar s_ready", longint'(s_ready), 1);
        check("midvar m_valid", longint'(m_valid), 0);
        check_outs("midvar", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(vecs[0].s, 1'b0, -6057, 18932, 2446, 54663520, "after-reset");
        pop(0);

        // Random frames against the reference model.
        for (int f = 0; f < 25; f++) begin
            frame_t smp;
            longint mn, mx, mu, dp;
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 5))
                    0: smp[j] = 16'h7FFF;
                    1: smp[j] = 16'h8000;
                    default: smp[j] = 16'($urandom);
                endcase
            end
            model(smp, mn, mx, mu, dp);
            run_frame(smp, 1'($urandom_range(0, 1)), mn, mx, mu, dp, $sformatf("rand%0d", f));
            pop(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
